// File: rtl/stereo_fir_pkg.sv
// stereo_fir_pkg: shared widths, default timeout and sequencer state encoding
// for the stereo FIR sequencer.
`default_nettype none

package stereo_fir_pkg;

    localparam int DW              = 16;
    localparam int CODEC_W         = 24;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START_L = 3'd1,
        S_WAIT_L  = 3'd2,
        S_START_R = 3'd3,
        S_WAIT_R  = 3'd4,
        S_OUT     = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/stereo_fir_seq.sv
// stereo_fir_seq: pops one stereo sample from the codec, runs each channel
// through a shared FIR engine (or bypasses it) and pushes the result back.
`default_nettype none

module stereo_fir_seq #(
    parameter int DW      = stereo_fir_pkg::DW,
    parameter int TIMEOUT = stereo_fir_pkg::TIMEOUT_DEFAULT
) (
    input  logic                               ck,
    input  logic                               rst,
    input  logic                               read_ready,
    input  logic [stereo_fir_pkg::CODEC_W-1:0] readdata_left,
    input  logic [stereo_fir_pkg::CODEC_W-1:0] readdata_right,
    output logic                               read,
    input  logic                               write_ready,
    output logic [stereo_fir_pkg::CODEC_W-1:0] writedata_left,
    output logic [stereo_fir_pkg::CODEC_W-1:0] writedata_right,
    output logic                               write,
    input  logic                               bypass,
    output logic [DW-1:0]                      fir_in,
    output logic                               fir_sel,
    output logic                               fir_start,
    input  logic [DW-1:0]                      fir_out,
    input  logic                               fir_done,
    output logic                               busy,
    output logic                               timeout_err
);
    import stereo_fir_pkg::*;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          r_state;
    state_t          w_next;
    logic [DW-1:0]   r_smp_l;
    logic [DW-1:0]   r_smp_r;
    logic [DW-1:0]   r_res_l;
    logic [DW-1:0]   r_res_r;
    logic [DW-1:0]   r_fir_in;
    logic            r_fir_sel;
    logic            r_terr;
    logic [CW-1:0]   r_cnt;
    logic            w_waiting;
    logic            w_tmo;
    logic            w_adv;
    logic [DW-1:0]   w_in_l;
    logic [DW-1:0]   w_in_r;
    logic            w_unused;

    assign w_in_l   = readdata_left[CODEC_W-1 -: DW];
    assign w_in_r   = readdata_right[CODEC_W-1 -: DW];
    assign w_unused = ^{readdata_left[CODEC_W-DW-1:0], readdata_right[CODEC_W-DW-1:0]};

    // The WAIT residency is TIMEOUT cycles; a done on the last one still wins.
    assign w_waiting = (r_state == S_WAIT_L) || (r_state == S_WAIT_R);
    assign w_tmo     = w_waiting && !fir_done && (r_cnt == CW'(TIMEOUT - 1));
    assign w_adv     = w_waiting && (fir_done || w_tmo);

    always_comb begin
        w_next    = r_state;
        read      = 1'b0;
        write     = 1'b0;
        fir_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (read_ready) begin
                    read   = 1'b1;
                    w_next = bypass ? S_OUT : S_START_L;
                end
            end
            S_START_L: begin
                fir_start = 1'b1;
                w_next    = S_WAIT_L;
            end
            S_WAIT_L:  if (w_adv) w_next = S_START_R;
            S_START_R: begin
                fir_start = 1'b1;
                w_next    = S_WAIT_R;
            end
            S_WAIT_R:  if (w_adv) w_next = S_OUT;
            S_OUT: begin
                if (write_ready) begin
                    write  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_smp_l   <= '0;
            r_smp_r   <= '0;
            r_res_l   <= '0;
            r_res_r   <= '0;
            r_fir_in  <= '0;
            r_fir_sel <= 1'b0;
            r_terr    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_waiting && !w_adv) ? r_cnt + 1'b1 : '0;
            if (w_tmo) r_terr <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (read_ready) begin
                        r_smp_l <= w_in_l;
                        r_smp_r <= w_in_r;
                        if (bypass) begin
                            r_res_l <= w_in_l;
                            r_res_r <= w_in_r;
                        end else begin
                            r_fir_in  <= w_in_l;
                            r_fir_sel <= 1'b0;
                        end
                    end
                end
                S_WAIT_L: begin
                    if (w_adv) begin
                        r_res_l   <= fir_done ? fir_out : '0;
                        r_fir_in  <= r_smp_r;
                        r_fir_sel <= 1'b1;
                    end
                end
                S_WAIT_R: begin
                    if (w_adv) r_res_r <= fir_done ? fir_out : '0;
                end
                default: ;
            endcase
        end
    end

    assign fir_in          = r_fir_in;
    assign fir_sel         = r_fir_sel;
    assign busy            = (r_state != S_IDLE);
    assign timeout_err     = r_terr;
    assign writedata_left  = {r_res_l, {(CODEC_W-DW){1'b0}}};
    assign writedata_right = {r_res_r, {(CODEC_W-DW){1'b0}}};

endmodule

`default_nettype wire

// File: tb/tb_stereo_fir_seq.sv
// tb_stereo_fir_seq: directed scoreboard bench; dut uses the default timeout,
// dut_t uses TIMEOUT=8 for the abandonment and boundary cases.
`default_nettype none

module tb_stereo_fir_seq;

    logic ck = 1'b0;
    logic rst;
    always #5 ck = ~ck;

    logic        rr, wrdy, byp, fdone, rd, wr, fsel, fstart, busy, terr;
    logic [23:0] rdl, rdr, wdl, wdr;
    logic [15:0] fout, fin;

    logic        t_rr, t_wrdy, t_byp, t_fdone, t_rd, t_wr, t_fsel, t_fstart, t_busy, t_terr;
    logic [23:0] t_rdl, t_rdr, t_wdl, t_wdr;
    logic [15:0] t_fout, t_fin;

    stereo_fir_seq #(.DW(16), .TIMEOUT(255)) dut (
        .ck(ck), .rst(rst), .read_ready(rr), .readdata_left(rdl), .readdata_right(rdr),
        .read(rd), .write_ready(wrdy), .writedata_left(wdl), .writedata_right(wdr),
        .write(wr), .bypass(byp), .fir_in(fin), .fir_sel(fsel), .fir_start(fstart),
        .fir_out(fout), .fir_done(fdone), .busy(busy), .timeout_err(terr)
    );

    stereo_fir_seq #(.DW(16), .TIMEOUT(8)) dut_t (
        .ck(ck), .rst(rst), .read_ready(t_rr), .readdata_left(t_rdl), .readdata_right(t_rdr),
        .read(t_rd), .write_ready(t_wrdy), .writedata_left(t_wdl), .writedata_right(t_wdr),
        .write(t_wr), .bypass(t_byp), .fir_in(t_fin), .fir_sel(t_fsel), .fir_start(t_fstart),
        .fir_out(t_fout), .fir_done(t_fdone), .busy(t_busy), .timeout_err(t_terr)
    );

    int tests = 0;
    int fails = 0;
    int wcnt = 0;
    int t_wcnt = 0;
    logic [47:0] q[$];
    logic [47:0] tq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    // Write-side scoreboards.
    always @(negedge ck) begin
        if (!rst) begin
            if (rd || wr) chk("rd_wr_exclusive", {63'd0, rd & wr}, 64'd0);
            if (wr) begin
                wcnt++;
                if (q.size() == 0) begin
                    tests++; fails++;
                    $error("FAIL unexpected_write: observed=%h expected=none", {wdl, wdr});
                end else chk("write_data", {wdl, wdr}, q.pop_front());
            end
            if (t_wr) begin
                t_wcnt++;
                if (tq.size() == 0) begin
                    tests++; fails++;
                    $error("FAIL unexpected_t_write: observed=%h expected=none", {t_wdl, t_wdr});
                end else chk("t_write_data", {t_wdl, t_wdr}, tq.pop_front());
            end
        end
    end

    // FIR engine model: done arrives lat cycles after the start cycle with ~fir_in.
    task automatic fir_serve(input bit t, input logic [15:0] exp_in, input logic exp_sel, input int lat);
        int n = 0;
        while (!(t ? t_fstart : fstart) && n < 40) begin
            @(negedge ck);
            n++;
        end
        chk("fir_start", {63'd0, t ? t_fstart : fstart}, 64'd1);
        chk("fir_sel_start", {63'd0, t ? t_fsel : fsel}, {63'd0, exp_sel});
        chk("fir_in_start", {48'd0, t ? t_fin : fin}, {48'd0, exp_in});
        @(posedge ck);
        @(negedge ck);
        chk("fir_hold_in_wait", {46'd0, t ? t_fsel : fsel, t ? t_fin : fin, t ? t_fstart : fstart},
            {46'd0, exp_sel, exp_in, 1'b0});
        repeat (lat - 1) @(posedge ck);
        #1;
        if (t) begin t_fdone = 1'b1; t_fout = ~t_fin; end
        else   begin fdone = 1'b1;   fout = ~fin;     end
        step();
        fdone   = 1'b0;
        t_fdone = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w0;
        rst = 1'b1;
        {rr, wrdy, byp, fdone} = '0; rdl = '0; rdr = '0; fout = '0;
        {t_rr, t_wrdy, t_byp, t_fdone} = '0; t_rdl = '0; t_rdr = '0; t_fout = '0;
        repeat (3) step();
        @(negedge ck);
        chk("reset_ctrl", {58'd0, busy, rd, wr, fstart, fsel, terr}, 64'd0);
        chk("reset_data", {fin, wdl, wdr}, 64'd0);
        chk("reset_t", {t_busy, t_terr, t_fin, t_wdl, t_wdr}, 64'd0);
        step();
        rst = 1'b0;

        // Bypass: read at T, write at T+1.
        step();
        byp = 1'b1; wrdy = 1'b1; rdl = 24'h123456; rdr = 24'hABCDEF; rr = 1'b1;
        q.push_back({24'h123400, 24'hABCD00});
        @(negedge ck);
        chk("bypass_read_T", {62'd0, rd, wr}, 64'd2);
        step();
        rr = 1'b0;
        @(negedge ck);
        chk("bypass_write_T1", {62'd0, rd, wr}, 64'd1);
        step();
        @(negedge ck);
        chk("bypass_idle", {63'd0, busy}, 64'd0);

        // Filtered, 10-cycle FIR latency.
        step();
        byp = 1'b0; rdl = 24'h00FF5A; rdr = 24'h1234AB; rr = 1'b1;
        q.push_back({24'hFF0000, 24'hEDCB00});
        step();
        rr = 1'b0;
        fir_serve(1'b0, 16'h00FF, 1'b0, 10);
        fir_serve(1'b0, 16'h1234, 1'b1, 10);
        @(negedge ck);
        chk("filt_write_after_done", {63'd0, wr}, 64'd1);
        chk("filt_no_terr", {63'd0, terr}, 64'd0);

        // Backpressure: 50 cycles in OUT with read_ready held high.
        step();
        byp = 1'b1; wrdy = 1'b0; rdl = 24'hAAAA55; rdr = 24'h5555AA; rr = 1'b1;
        q.push_back({24'hAAAA00, 24'h555500});
        step();
        w0 = wcnt;
        for (int i = 0; i < 50; i++) begin
            @(negedge ck);
            chk("bp_hold", {14'd0, rd, wr, wdl, wdr}, {16'd0, 24'hAAAA00, 24'h555500});
        end
        step();
        wrdy = 1'b1;
        @(negedge ck);
        chk("bp_release", {62'd0, rd, wr}, 64'd1);
        step();
        rr = 1'b0;
        repeat (3) step();
        chk("bp_single_write", wcnt - w0, 64'd1);

        // Reset during WAIT_R, stray done two cycles later.
        step();
        byp = 1'b0; rdl = 24'h0102FF; rdr = 24'h0304FF; rr = 1'b1;
        step();
        rr = 1'b0;
        fir_serve(1'b0, 16'h0102, 1'b0, 2);
        step();
        step();
        @(negedge ck);
        chk("in_wait_r", {62'd0, busy, fsel}, 64'd3);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge ck);
        chk("midrst_ctrl", {58'd0, busy, rd, wr, fstart, fsel, terr}, 64'd0);
        chk("midrst_data", {fin, wdl, wdr}, 64'd0);
        step();
        fdone = 1'b1; fout = 16'hBEEF;
        step();
        fdone = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ck);
            chk("stray_done_ignored", {61'd0, busy, wr, fstart}, 64'd0);
        end

        // Timeout (TIMEOUT=8): each channel abandoned after 8 WAIT cycles.
        step();
        t_byp = 1'b0; t_wrdy = 1'b1; t_rdl = 24'h777777; t_rdr = 24'h888888; t_rr = 1'b1;
        tq.push_back(48'd0);
        step();
        t_rr = 1'b0;
        @(negedge ck);
        chk("tmo_start_l", {46'd0, t_fstart, t_fsel, t_fin}, {46'd0, 2'b10, 16'h7777});
        n = 0;
        do begin step(); n++; end while (!t_fstart && n < 30);
        chk("tmo_left_len", n, 64'd9);
        chk("tmo_start_r", {45'd0, t_terr, t_fstart, t_fsel, t_fin}, {45'd0, 3'b111, 16'h8888});
        n = 0;
        do begin step(); n++; end while (!t_wr && n < 30);
        chk("tmo_right_len", n, 64'd9);
        step();
        repeat (4) step();
        chk("tmo_sticky", {63'd0, t_terr}, 64'd1);

        // Done on the final WAIT cycle counts as success.
        t_rdl = 24'h0F0F00; t_rdr = 24'h00010A; t_rr = 1'b1;
        tq.push_back({24'hF0F000, 24'hFFFE00});
        step();
        t_rr = 1'b0;
        fir_serve(1'b1, 16'h0F0F, 1'b0, 8);
        fir_serve(1'b1, 16'h0001, 1'b1, 8);
        @(negedge ck);
        chk("boundary_write", {62'd0, t_wr, t_terr}, 64'd3);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge ck);
        chk("terr_cleared_by_rst", {63'd0, t_terr}, 64'd0);

        chk("q_drained", q.size(), 64'd0);
        chk("tq_drained", tq.size(), 64'd0);
        chk("write_count", wcnt, 64'd3);
        chk("t_write_count", t_wcnt, 64'd2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
